// File: rtl/aes_pkg.sv
// Shared AES types, tables and GF(2^8) round primitives for the encoder pipeline.
package aes_pkg;

  typedef logic [7:0] byte_t;
  localparam int unsigned AES_STATE_SIZE = 16;
  typedef byte_t [0:AES_STATE_SIZE-1] state_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Index 0 is never used; key expansion indexes by i/NK starting at 1.
  localparam byte_t RCON [11] = '{
    8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic state_t sub_bytes(input state_t s);
    state_t res;
    for (int i = 0; i < AES_STATE_SIZE; i++) res[i] = SBOX[s[i]];
    return res;
  endfunction

  // Column-major state: byte 4*c+r sits at row r, column c.
  function automatic state_t shift_rows(input state_t s);
    state_t res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[4*c+r] = s[4*((c+r)%4)+r];
    return res;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t res;
    byte_t a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c];
      a1 = s[4*c+1];
      a2 = s[4*c+2];
      a3 = s[4*c+3];
      res[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      res[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      res[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      res[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return res;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One registered AES encryption round plus the key-expansion step that yields its round key.
module aes_enc_round
  import aes_pkg::*;
#(
  parameter int unsigned NK    = 4,
  parameter int unsigned ROUND = 1,
  parameter bit          FINAL = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  state_t               stateIn,
  input  logic [0:NK-1][31:0]  winIn,
  output state_t               stateOut,
  output logic [0:NK-1][31:0]  winOut
);

  // winIn holds words w[4*(ROUND-1) .. 4*(ROUND-1)+NK-1]; four new words slide it forward.
  localparam int unsigned BASE = 4 * (ROUND - 1) + NK;

  logic [0:NK-1][31:0] winNext;
  state_t              shifted;
  state_t              mixed;
  state_t              stateNext;

  always_comb begin : keyStep
    logic [31:0]  ext [0:NK+3];
    logic [31:0]  temp;
    int unsigned  idx;
    winNext = '0;
    for (int j = 0; j < NK; j++) ext[j] = winIn[j];
    for (int j = 0; j < 4; j++) begin
      idx  = BASE + 32'(j);
      temp = ext[NK+j-1];
      if (idx % NK == 0)
        temp = sub_word(rot_word(temp)) ^ {RCON[4'(idx / NK)], 24'h000000};
      else if (NK > 6 && idx % NK == 4)
        temp = sub_word(temp);
      ext[NK+j] = ext[j] ^ temp;
    end
    for (int j = 0; j < NK; j++) winNext[j] = ext[j+4];
  end

  always_comb begin : roundStep
    shifted = shift_rows(sub_bytes(stateIn));
    if (FINAL) mixed = shifted;
    else       mixed = mix_columns(shifted);
    stateNext = mixed ^ state_t'(winNext[0:3]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateOut <= '0;
      winOut   <= '0;
    end else begin
      stateOut <= stateNext;
      winOut   <= winNext;
    end
  end

endmodule

// File: rtl/aes_encoder_pipe.sv
// Fully pipelined AES-128/192/256 encryptor, one block and key per cycle, latency NR.
// Define AES_KEYOUT_EN to add key_out, the input key delayed to line up with encrypted.
module aes_encoder_pipe
  import aes_pkg::*;
#(
  parameter int unsigned KEY_SIZE = 128
) (
  input  logic                       clock,
  input  logic                       reset,
  input  state_t                     plain,
  input  byte_t [0:KEY_SIZE/8-1]     key,
  output state_t                     encrypted,
  output logic                       valid
`ifdef AES_KEYOUT_EN
  ,
  output byte_t [0:KEY_SIZE/8-1]     key_out
`endif
);

  localparam int unsigned NK = KEY_SIZE / 32;
  localparam int unsigned NR = NK + 6;

  if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : gBadKeySize
    $error("aes_encoder_pipe: KEY_SIZE must be 128, 192 or 256");
  end

  state_t              stateP [0:NR];
  logic [0:NK-1][31:0] winP   [0:NR];
  logic [NR-1:0]       validSr;

  // Round key 0 is the first four key words, applied before the first register.
  assign winP[0]   = key;
  assign stateP[0] = plain ^ state_t'(winP[0][0:3]);

  for (genvar r = 1; r <= NR; r++) begin : gRound
    aes_enc_round #(
      .NK    (NK),
      .ROUND (r),
      .FINAL (r == NR)
    ) uRound (
      .clock    (clock),
      .reset    (reset),
      .stateIn  (stateP[r-1]),
      .winIn    (winP[r-1]),
      .stateOut (stateP[r]),
      .winOut   (winP[r])
    );
  end

  assign encrypted = stateP[NR];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) validSr <= '0;
    else       validSr <= {validSr[NR-2:0], 1'b1};
  end

  assign valid = validSr[NR-1];

`ifdef AES_KEYOUT_EN
  byte_t [0:KEY_SIZE/8-1] keyDly [0:NR-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) keyDly[i] <= '0;
    end else begin
      keyDly[0] <= key;
      for (int i = 1; i < NR; i++) keyDly[i] <= keyDly[i-1];
    end
  end

  assign key_out = keyDly[NR-1];
`endif

endmodule

// File: tb/tb_aes_encoder_pipe.sv
// Directed FIPS-197 vectors against 128/192/256-bit instances, including back-to-back and reset refill.
module tb_aes_encoder_pipe;
  import aes_pkg::*;

  localparam logic [127:0] P1   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C2   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  state_t        plain128, plain192, plain256;
  state_t        enc128, enc192, enc256;
  byte_t [0:15]  key128;
  byte_t [0:23]  key192;
  byte_t [0:31]  key256;
  logic          valid128, valid192, valid256;
`ifdef AES_KEYOUT_EN
  byte_t [0:15]  keyOut128;
  byte_t [0:23]  keyOut192;
  byte_t [0:31]  keyOut256;
`endif

  int nAsserts = 0;
  int nFails   = 0;

  aes_encoder_pipe #(.KEY_SIZE(128)) u128 (
    .clock(clock), .reset(reset), .plain(plain128), .key(key128),
    .encrypted(enc128), .valid(valid128)
`ifdef AES_KEYOUT_EN
    , .key_out(keyOut128)
`endif
  );

  aes_encoder_pipe #(.KEY_SIZE(192)) u192 (
    .clock(clock), .reset(reset), .plain(plain192), .key(key192),
    .encrypted(enc192), .valid(valid192)
`ifdef AES_KEYOUT_EN
    , .key_out(keyOut192)
`endif
  );

  aes_encoder_pipe #(.KEY_SIZE(256)) u256 (
    .clock(clock), .reset(reset), .plain(plain256), .key(key256),
    .encrypted(enc256), .valid(valid256)
`ifdef AES_KEYOUT_EN
    , .key_out(keyOut256)
`endif
  );

  task automatic checkBlock(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Checks all three instances after the k-th edge since reset release.
  task automatic checkCycle(input string phase, input int k, input bit firstV1);
    logic [127:0] exp128;
    bit           inWasV1;
    checkBit($sformatf("%s valid128 k=%0d", phase, k), valid128, k >= 10);
    checkBit($sformatf("%s valid192 k=%0d", phase, k), valid192, k >= 12);
    checkBit($sformatf("%s valid256 k=%0d", phase, k), valid256, k >= 14);
    if (k >= 10) begin
      inWasV1 = (((k - 9) % 2) == 1) ? firstV1 : !firstV1;
      exp128  = inWasV1 ? C1 : C2;
      checkBlock($sformatf("%s enc128 k=%0d", phase, k), enc128, exp128);
`ifdef AES_KEYOUT_EN
      checkBlock($sformatf("%s keyout128 k=%0d", phase, k), keyOut128, inWasV1 ? K1 : K2);
`endif
    end
    if (k >= 12) checkBlock($sformatf("%s enc192 k=%0d", phase, k), enc192, C192);
    if (k >= 14) checkBlock($sformatf("%s enc256 k=%0d", phase, k), enc256, C256);
  endtask

  task automatic drive128(input bit useV1);
    plain128 = useV1 ? P1 : P2;
    key128   = useV1 ? K1 : K2;
  endtask

  task automatic checkCleared(input string phase);
    checkBlock({phase, " enc128"}, enc128, '0);
    checkBlock({phase, " enc192"}, enc192, '0);
    checkBlock({phase, " enc256"}, enc256, '0);
    checkBit({phase, " valid128"}, valid128, 1'b0);
    checkBit({phase, " valid192"}, valid192, 1'b0);
    checkBit({phase, " valid256"}, valid256, 1'b0);
`ifdef AES_KEYOUT_EN
    checkBlock({phase, " keyout128"}, keyOut128, '0);
    checkBit({phase, " keyout192 nonzero"}, |keyOut192, 1'b0);
    checkBit({phase, " keyout256 nonzero"}, |keyOut256, 1'b0);
`endif
  endtask

  initial begin
    reset    = 1'b1;
    plain128 = '0;
    key128   = '0;
    plain192 = P2;
    key192   = K192;
    plain256 = P2;
    key256   = K256;
    repeat (3) @(posedge clock);
    #1;
    checkCleared("reset");

    // Release, then alternate the two 128-bit vectors every cycle.
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      drive128((k % 2) == 1);
      @(posedge clock);
      #1;
      checkCycle("fill", k, 1'b1);
    end

    // Mid-stream reset clears the pipe without waiting for a clock edge.
    reset = 1'b1;
    #1;
    checkCleared("midreset");
    @(posedge clock);
    #1;
    checkCleared("midreset held");
    reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      drive128((k % 2) == 0);
      @(posedge clock);
      #1;
      checkCycle("refill", k, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
